// File: rtl/mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_seq : K-pair dot-product sequencer wrapped around an external MAC.     |
// | Optional macro MAC_SEQ_SKIP_ZERO_EN: zero-operand pairs bypass the MAC.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mac_seq #(
  parameter int INW  = 16,
  parameter int OUTW = 48,
  parameter int K    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  in_data0,
  input  logic [INW-1:0]  in_data1,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [INW-1:0]  mac_in0,
  output logic [INW-1:0]  mac_in1,
  output logic            mac_valid_input,
  output logic            mac_clear_acc,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int              CNTW   = $clog2(K);
  localparam logic [CNTW-1:0] c_LAST = CNTW'(K - 1);

  localparam logic [1:0] c_ACCUM   = 2'd0;
  localparam logic [1:0] c_FLUSH   = 2'd1;
  localparam logic [1:0] c_CAPTURE = 2'd2;

  logic [1:0]      r_state;
  logic [CNTW-1:0] r_count;
  logic [INW-1:0]  r_mac_in0;
  logic [INW-1:0]  r_mac_in1;
  logic            r_mac_valid;
  logic [OUTW-1:0] r_out_data;
  logic            r_out_valid;

  logic w_in_hs;
  logic w_buf_free;
  logic w_load;
  logic w_fwd;

  assign in_ready   = (r_state == c_ACCUM);
  assign w_in_hs    = in_valid && in_ready;
  assign w_buf_free = !r_out_valid || out_ready;
  // The MAC clears at the same edge the result is copied out.
  assign w_load     = (r_state == c_CAPTURE) && w_buf_free;

`ifdef MAC_SEQ_SKIP_ZERO_EN
  assign w_fwd = (in_data0 != '0) && (in_data1 != '0);
`else
  assign w_fwd = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_ACCUM;
      r_count     <= '0;
      r_mac_in0   <= '0;
      r_mac_in1   <= '0;
      r_mac_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_ACCUM: begin
          if (w_in_hs) begin
            if (w_fwd) begin
              r_mac_in0   <= in_data0;
              r_mac_in1   <= in_data1;
              r_mac_valid <= 1'b1;
            end else begin
              r_mac_valid <= 1'b0;
            end
            if (r_count == c_LAST) begin
              r_count <= '0;
              r_state <= c_FLUSH;
            end else begin
              r_count <= r_count + CNTW'(1);
            end
          end else begin
            r_mac_valid <= 1'b0;
          end
        end
        c_FLUSH: begin
          r_mac_valid <= 1'b0;
          r_state     <= c_CAPTURE;
        end
        c_CAPTURE: begin
          r_mac_valid <= 1'b0;
          if (w_buf_free) r_state <= c_ACCUM;
        end
        default: begin
          r_state     <= c_ACCUM;
          r_count     <= '0;
          r_mac_valid <= 1'b0;
        end
      endcase

      // A load wins over a concurrent handshake so back-to-back results stream.
      if (w_load) begin
        r_out_data  <= mac_out;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign mac_in0         = r_mac_in0;
  assign mac_in1         = r_mac_in1;
  assign mac_valid_input = r_mac_valid;
  assign mac_clear_acc   = w_load;
  assign out_data        = r_out_data;
  assign out_valid       = r_out_valid;

endmodule
`default_nettype wire
